// File: rtl/fu_addsub32_seq.sv
// fu_addsub32_seq
//   Two-requester sequencer for a shared external 16-bit adder. Each accepted
//   32-bit add/subtract runs as two adder passes: the low half, then the high
//   half with the carry chained in from the low pass. Only one operation is in
//   flight at a time. Ties between requesters are broken round-robin.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/ready           requester N handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_sub   requester N operands, 1 = A-B, 0 = A+B
//   rsp_valid/ready            result handshake
//   rsp_id                     requester that owns the result
//   rsp_sum/carry/overflow     32-bit result, carry out of bit 31, signed ovf
//   add_din1/din2/cin          to the shared adder
//   add_dout/cout/ovf          from the shared adder (combinational)
//
// state | meaning
// IDLE  | waiting for a request, grants and captures operands
// LO    | adder busy with bits 15:0
// HI    | adder busy with bits 31:16, carry from LO chained in
// RESP  | result presented until rsp_ready
module fu_addsub32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic [15:0] add_din1,
  output logic [15:0] add_din2,
  output logic        add_cin,
  input  logic [15:0] add_dout,
  input  logic        add_cout,
  input  logic        add_ovf
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic [31:0] op_a;
  logic [31:0] op_b;   // already inverted for subtract
  logic        op_sub;
  logic        op_id;
  logic        c_lo;

  logic        grant_any;
  logic        grant_id;
  logic        accept_ok;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_sub;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid)
      grant_id = ~last_grant;
    else
      grant_id = req1_valid;
    sel_a   = grant_id ? req1_a   : req0_a;
    sel_b   = grant_id ? req1_b   : req0_b;
    sel_sub = grant_id ? req1_sub : req0_sub;
  end

  // Ready is gated by rst_n so nothing looks accepted in a reset cycle.
  assign accept_ok  = rst_n && (state == IDLE) && grant_any;
  assign req0_ready = accept_ok && !grant_id;
  assign req1_ready = accept_ok && grant_id;

  // Subtract is A + ~B + 1: the +1 enters as the low-pass carry in.
  always_comb begin
    add_din1 = '0;
    add_din2 = '0;
    add_cin  = 1'b0;
    case (state)
      LO: begin
        add_din1 = op_a[15:0];
        add_din2 = op_b[15:0];
        add_cin  = op_sub;
      end
      HI: begin
        add_din1 = op_a[31:16];
        add_din2 = op_b[31:16];
        add_cin  = c_lo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_sub       <= 1'b0;
      op_id        <= 1'b0;
      c_lo         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a       <= sel_a;
            op_b       <= sel_sub ? ~sel_b : sel_b;
            op_sub     <= sel_sub;
            op_id      <= grant_id;
            last_grant <= grant_id;
            state      <= LO;
          end
        end
        LO: begin
          // low-half overflow is meaningless, so add_ovf is not taken here
          rsp_sum[15:0] <= add_dout;
          c_lo          <= add_cout;
          state         <= HI;
        end
        HI: begin
          rsp_sum[31:16] <= add_dout;
          rsp_carry      <= add_cout;
          rsp_overflow   <= add_ovf;
          rsp_id         <= op_id;
          rsp_valid      <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fu_addsub32_seq.md
Name: fu_addsub32_seq

Overview:
- Two-requester sequencer that shares one external 16-bit carry-select adder with overflow detection.
- Each accepted request is a 32-bit add or subtract, run as two passes through the adder: low half, then high half with the chained carry.
- Sits between the ALU issue logic and the shared adder; the adder itself is instantiated outside this block.

Parameters:
- none (operand width fixed at 32, adder slice width fixed at 16, two requesters)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  32  requester 0 operand A
- req0_b  in  32  requester 0 operand B
- req0_sub  in  1  requester 0: 1 = A-B, 0 = A+B
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  index of the requester that owns the result
- rsp_sum  out  32  result
- rsp_carry  out  1  carry out of bit 31 (for subtract: 1 = no borrow)
- rsp_overflow  out  1  signed overflow
- add_din1  out  16  to shared adder operand 1
- add_din2  out  16  to shared adder operand 2
- add_cin  out  1  to shared adder carry_in
- add_dout  in  16  from shared adder sum (combinational)
- add_cout  in  1  from shared adder carry_out
- add_ovf  in  1  from shared adder overflow

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. The block samples reset only on a rising clk edge.
- Reset state:
  - FSM = IDLE; last-grant pointer = 1, so requester 0 wins the first tie.
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_carry = 0, rsp_overflow = 0.
  - req0_ready = req1_ready = 0; add_din1 = add_din2 = 0, add_cin = 0.
- FSM states: IDLE, LO, HI, RESP.
- IDLE:
  - If exactly one reqN_valid is high, grant it. If both are high, grant the requester other than last-grant.
  - reqN_ready for the granted requester is asserted combinationally in that cycle; the other ready stays 0. A handshake is valid & ready.
  - On accept, capture A, B' = sub ? ~B : B, sub flag and grant index; update last-grant; go to LO.
  - With no valid request, stay in IDLE.
- LO:
  - Drive add_din1 = A[15:0], add_din2 = B'[15:0], add_cin = sub.
  - Register add_dout into sum[15:0] and add_cout into c_lo; go to HI.
  - add_ovf is ignored in this state.
- HI:
  - Drive add_din1 = A[31:16], add_din2 = B'[31:16], add_cin = c_lo.
  - Register add_dout into sum[31:16], add_cout into rsp_carry, add_ovf into rsp_overflow; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_sum, rsp_carry and rsp_overflow stay stable.
  - When rsp_ready = 1, go to IDLE; rsp_valid is 0 the next cycle.
  - With rsp_ready = 0, hold indefinitely.
- In IDLE and RESP, add_din1 = add_din2 = 0 and add_cin = 0.
- In every state except IDLE, both reqN_ready are 0. Requests arriving while busy wait; their valid must stay high until ready.
- Latency: accept at cycle N, rsp_valid at N+3. Minimum issue interval is 4 cycles, since IDLE follows RESP.
- Arithmetic: result is modulo 2^32. Overflow and carry follow standard two's-complement add, with subtract done as A + ~B + 1.
- Reset mid-operation (any state): the in-flight operation is discarded and no response is produced. The next cycle is IDLE with all outputs at their reset values.
- Registered result outputs keep the last result after rsp_valid falls; they are don't-care when rsp_valid = 0.

Test Plan:
- Chained carry: req0 A=0x0000FFFF, B=0x00000001, add. Expect add_cin=1 in HI; rsp_valid 3 cycles after accept; rsp_sum=0x00010000, carry=0, overflow=0, rsp_id=0.
- Subtract: req1 A=0x80000000, B=0x00000001, sub. Expect add_cin=1 in LO; rsp_sum=0x7FFFFFFF, carry=1, overflow=1, rsp_id=1.
- Add boundaries:
  - 0x7FFFFFFF + 0x00000001 → 0x80000000, carry=0, overflow=1.
  - 0xFFFFFFFF + 0x00000001 → 0x00000000, carry=1, overflow=0.
- Arbitration: both valid continuously after reset, rsp_ready=1. Expect grants 0,1,0,1, accepts 4 cycles apart, only one ready high per accept cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Expect rsp outputs stable, both req ready 0, accept only after the rsp_ready handshake.
- Reset mid-op: assert rst_n=0 for one cycle while in HI. Expect no rsp_valid, all outputs at reset values, and requester 0 wins the next tie.
